// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared types for the switch conditioning path. The LED sequencer and the
// future mode logic import the same state encoding, so a debug probe on the
// debouncer state decodes identically everywhere.
//
// Contents:
//   sw_state_t         - debouncer FSM state
//   sw_level_of(state) - accepted level implied by a debouncer state
// -----------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [1:0] {
    SW_LOW       = 2'd0,
    SW_RISE_WAIT = 2'd1,
    SW_HIGH      = 2'd2,
    SW_FALL_WAIT = 2'd3
  } sw_state_t;

  // FALL_WAIT still reports high: the level only drops once the low run has
  // been accepted.
  function automatic logic sw_level_of(input sw_state_t state);
    return (state == SW_HIGH) || (state == SW_FALL_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Parameter-free so it
// can be dropped onto any pad signal (switch, reset button).
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronised output, two clock edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its source; with = the second stage would see the
  // new value of the first and the chain would collapse to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
// Cleans up the raw control switch before it reaches the LED sequencer:
// synchronise, debounce with a four-state FSM, and derive single-cycle edge and
// long-hold pulses. All outputs are flops; nothing combinational reaches them
// from sw_raw.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronised samples needed to accept a change (>=2)
//   HOLD_CYCLES     - accepted-high cycles before sw_hold fires (> DEBOUNCE_CYCLES)
//
// Ports:
//   clkIn    - board clock, rising edge
//   rst_n    - asynchronous active-low reset
//   sw_raw   - raw, asynchronous, bouncing switch pin
//   sw_level - debounced level, drives control_switch of the LED stage
//   sw_rise  - one-cycle pulse on an accepted 0->1 change
//   sw_fall  - one-cycle pulse on an accepted 1->0 change
//   sw_hold  - one-cycle pulse, at most once per accepted high period
// -----------------------------------------------------------------------------
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic clkIn,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_hold
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  // One extra count of headroom so the saturation value itself is
  // representable even when HOLD_CYCLES is a power of two.
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic              sync_q;
  sw_state_t         state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic db_done;
  logic rise_done;
  logic fall_done;
  logic hold_run;

  sync_2ff u_sync (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (sw_raw),
    .q     (sync_q)
  );

  assign db_done   = (db_cnt == DB_LAST);
  assign rise_done = (state == SW_RISE_WAIT) &&  sync_q && db_done;
  assign fall_done = (state == SW_FALL_WAIT) && !sync_q && db_done;
  // The hold counter stops on the edge that accepts a fall, so a hold that
  // would have landed on that same edge is suppressed and never overlaps
  // sw_fall.
  assign hold_run  = sw_level_of(state) && !fall_done;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SW_LOW;
      db_cnt   <= '0;
      hold_cnt <= '0;
      sw_level <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
      sw_hold  <= 1'b0;
    end else begin
      // Pulses are registered from the same decode that moves the state, so
      // they line up with the first cycle of the new sw_level.
      sw_rise <= rise_done;
      sw_fall <= fall_done;
      sw_hold <= 1'b0;

      case (state)
        SW_LOW: begin
          if (sync_q) begin
            state  <= SW_RISE_WAIT;
            db_cnt <= '0;
          end
        end
        SW_RISE_WAIT: begin
          if (!sync_q) begin
            state <= SW_LOW;
          end else if (db_done) begin
            state    <= SW_HIGH;
            sw_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        SW_HIGH: begin
          if (!sync_q) begin
            state  <= SW_FALL_WAIT;
            db_cnt <= '0;
          end
        end
        SW_FALL_WAIT: begin
          if (sync_q) begin
            // Bounce back to high: hold_cnt keeps running untouched.
            state <= SW_HIGH;
          end else if (db_done) begin
            state    <= SW_LOW;
            sw_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state <= SW_LOW;
        end
      endcase

      // Saturating at HOLD_CYCLES makes the HOLD_CYCLES-1 match unreachable
      // again until the next accepted rise clears the counter.
      if (rise_done) begin
        hold_cnt <= '0;
      end else if (hold_run && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
        sw_hold  <= (hold_cnt == HOLD_LAST);
      end
    end
  end

endmodule
